// File: rtl/paddle_ctrl.sv
// Paddle controller: 2-FF button sync, per-button debounce, IDLE/SLOW/FAST motion FSM
// and wall-clamped position. Define PADDLE_AUTO_TRACK_EN to add ball auto-tracking.
module paddle_ctrl #(
   parameter int unsigned SCREEN_H        = 480,
   parameter int unsigned PADDLE_H        = 40,
   parameter int unsigned RESET_POS       = 220,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned SLOW_STEP       = 2,
   parameter int unsigned FAST_STEP       = 6,
   parameter int unsigned ACCEL_FRAMES    = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       frame_tick,
`ifdef PADDLE_AUTO_TRACK_EN
   input  logic       auto_en,
   input  logic [9:0] ball_y_pos,
`endif
   output logic [9:0] paddle_pos,
   output logic       paddle_mov,
   output logic       paddle_dir
);

   localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned AccW   = $clog2(ACCEL_FRAMES + 1);
   localparam logic [10:0] MaxPos = 11'(SCREEN_H - PADDLE_H);

   typedef enum logic [1:0] {StIdle, StSlow, StFast} state_e;
   typedef enum logic [1:0] {DirNone, DirUp, DirDown} dir_e;

   // Bit 0 is the up button, bit 1 the down button.
   logic [1:0]           sync1_q, sync1_d, sync2_q, sync2_d, clean_q, clean_d;
   logic [1:0][CntW-1:0] db_cnt_q, db_cnt_d;
   state_e               state_q, state_d;
   logic [AccW-1:0]      acc_q, acc_d;
   logic [9:0]           pos_q, pos_d;
   logic                 dir_q, dir_d;
   dir_e                 cmd_dir;
   logic                 cmd_down, mode_chg, fast_ok;
   logic [10:0]          pos_ext, step, pos_sum;

   assign pos_ext  = {1'b0, pos_q};
   assign cmd_down = (cmd_dir == DirDown);

   always_comb begin
      sync1_d  = {btn_down, btn_up};
      sync2_d  = sync1_q;
      clean_d  = clean_q;
      db_cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != clean_q[i]) begin
            if (db_cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
               clean_d[i] = ~clean_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

`ifdef PADDLE_AUTO_TRACK_EN
   logic        auto_q, auto_d;
   logic [10:0] ball_ext, target;

   assign ball_ext = {1'b0, ball_y_pos};
   assign auto_d   = frame_tick ? auto_en : auto_q;
   assign mode_chg = auto_en ^ auto_q;
   assign fast_ok  = ~auto_en;

   always_comb begin
      target = (ball_ext < 11'(PADDLE_H / 2)) ? 11'd0 : ball_ext - 11'(PADDLE_H / 2);
      if (target > MaxPos) target = MaxPos;
      cmd_dir = DirNone;
      if (auto_en) begin
         if (target > pos_ext + 11'(SLOW_STEP)) cmd_dir = DirDown;
         else if (target + 11'(SLOW_STEP) < pos_ext) cmd_dir = DirUp;
      end else if (clean_q[0] && !clean_q[1]) begin
         cmd_dir = DirUp;
      end else if (clean_q[1] && !clean_q[0]) begin
         cmd_dir = DirDown;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) auto_q <= 1'b0;
      else        auto_q <= auto_d;
   end
`else
   assign mode_chg = 1'b0;
   assign fast_ok  = 1'b1;

   always_comb begin
      cmd_dir = DirNone;
      if (clean_q[0] && !clean_q[1])      cmd_dir = DirUp;
      else if (clean_q[1] && !clean_q[0]) cmd_dir = DirDown;
   end
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
      end
   end

   // FSM next state; acc_q counts SLOW ticks after the first and saturates
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      if (frame_tick) begin
         if (mode_chg || cmd_dir == DirNone) begin
            state_d = StIdle;
            acc_d   = '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  state_d = StSlow;
                  acc_d   = '0;
               end
               StSlow: begin
                  if (cmd_down != dir_q) begin
                     acc_d = '0;
                  end else if (acc_q != AccW'(ACCEL_FRAMES - 1)) begin
                     acc_d = acc_q + 1'b1;
                  end else if (fast_ok) begin
                     state_d = StFast;
                  end
               end
               StFast: begin
                  if (cmd_down != dir_q) begin
                     state_d = StSlow;
                     acc_d   = '0;
                  end
               end
               default: begin
                  state_d = StIdle;
                  acc_d   = '0;
               end
            endcase
         end
      end
   end

   // FSM outputs
   always_comb begin
      paddle_mov = (state_q != StIdle);
      paddle_pos = pos_q;
      paddle_dir = dir_q;
   end

   always_comb begin
      unique case (state_d)
         StSlow:  step = 11'(SLOW_STEP);
         StFast:  step = 11'(FAST_STEP);
         default: step = 11'd0;
      endcase
      pos_sum = pos_ext + step;
      pos_d   = pos_q;
      dir_d   = dir_q;
      if (frame_tick && state_d != StIdle) begin
         dir_d = cmd_down;
         if (cmd_down) begin
            pos_d = (pos_sum > MaxPos) ? MaxPos[9:0] : pos_sum[9:0];
         end else begin
            pos_d = (pos_ext < step) ? 10'd0 : pos_q - step[9:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         clean_q  <= '0;
         db_cnt_q <= '0;
         pos_q    <= 10'(RESET_POS);
         dir_q    <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         clean_q  <= clean_d;
         db_cnt_q <= db_cnt_d;
         pos_q    <= pos_d;
         dir_q    <= dir_d;
      end
   end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed scenarios plus random button/tick traffic, scored against
// a frame-level model of debounce, acceleration and clamping.
module tb_paddle_ctrl;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       frame_tick = 1'b0;
   logic [9:0] paddle_pos;
   logic       paddle_mov, paddle_dir;
`ifdef PADDLE_AUTO_TRACK_EN
   logic       auto_en = 1'b0;
   logic [9:0] ball_y_pos = 10'd0;
`endif

   paddle_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .frame_tick (frame_tick),
`ifdef PADDLE_AUTO_TRACK_EN
      .auto_en    (auto_en),
      .ball_y_pos (ball_y_pos),
`endif
      .paddle_pos (paddle_pos),
      .paddle_mov (paddle_mov),
      .paddle_dir (paddle_dir)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [9:0] pos; logic mov; logic dir;} exp_t;
   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   chk_en = 1'b1;
   logic tick_s = 1'b0;

   // Reference model state
   int m_pos, m_run;
   bit m_mov, m_dir;
   bit m_clean[2];
   bit hist_up[$];
   bit hist_dn[$];

   task automatic model_reset();
      m_pos = 220; m_run = 0; m_mov = 0; m_dir = 0;
      m_clean[0] = 0; m_clean[1] = 0;
      hist_up.delete(); hist_dn.delete(); exp_q.delete();
   endtask

   // Synchronised value seen by the debouncer k edges ago: the raw sample two edges earlier.
   function automatic bit sync_at(input int b, input int k);
      int idx;
      idx = ((b == 0) ? hist_up.size() : hist_dn.size()) - 3 - k;
      if (idx < 0) return 1'b0;
      return (b == 0) ? hist_up[idx] : hist_dn[idx];
   endfunction

   task automatic model_edge(input bit up, input bit dn, input bit tk);
      bit all_diff, d;
      int step;
      hist_up.push_back(up);
      hist_dn.push_back(dn);
      if (tk) begin
         if (m_clean[0] == m_clean[1]) begin
            m_mov = 0; m_run = 0;
         end else begin
            d = m_clean[1];
            m_run = (m_mov && d == m_dir) ? m_run + 1 : 1;
            m_mov = 1; m_dir = d;
            step = (m_run <= 15) ? 2 : 6;
            if (d) m_pos = (m_pos + step > 440) ? 440 : m_pos + step;
            else   m_pos = (m_pos < step) ? 0 : m_pos - step;
         end
         exp_q.push_back({10'(m_pos), m_mov, m_dir});
      end
      // A button is accepted once the synchronised value has differed for D edges in a row.
      for (int b = 0; b < 2; b++) begin
         all_diff = 1;
         for (int k = 0; k < D; k++) if (sync_at(b, k) == m_clean[b]) all_diff = 0;
         if (all_diff) m_clean[b] = !m_clean[b];
      end
   endtask

   task automatic cyc(input bit up, input bit dn, input bit tk);
      btn_up = up; btn_down = dn; frame_tick = tk;
      @(posedge clk);
      model_edge(up, dn, tk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic do_reset();
      cyc(btn_up, btn_down, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("reset_pos", int'(paddle_pos), 220);
      chk("reset_mov", int'(paddle_mov), 0);
      chk("reset_dir", int'(paddle_dir), 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   always @(posedge clk) tick_s <= frame_tick && rst_n && chk_en;

   always @(negedge clk) begin
      exp_t e;
      if (tick_s) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: output on tick with no expected entry, pos=%0d", paddle_pos);
         end else begin
            e = exp_q.pop_front();
            if (paddle_pos !== e.pos || paddle_mov !== e.mov || paddle_dir !== e.dir) begin
               miscompares++;
               $display("FAIL tick_out: got pos=%0d mov=%0b dir=%0b, expected pos=%0d mov=%0b dir=%0b",
                        paddle_pos, paddle_mov, paddle_dir, e.pos, e.mov, e.dir);
            end
         end
      end
   end

   initial begin
      int seg, len;
      bit up, dn;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("init_pos", int'(paddle_pos), 220);
      chk("init_mov", int'(paddle_mov), 0);
      chk("init_dir", int'(paddle_dir), 0);
      rst_n = 1'b1;

      // Short glitch on up is rejected
      repeat (3) cyc(1, 0, 0);
      repeat (4) cyc(0, 0, 0);
      repeat (10) cyc(0, 0, 1);
      chk("glitch_pos", int'(paddle_pos), 220);

      // Down held: 15 slow ticks then fast
      repeat (2 + D) cyc(0, 1, 0);
      repeat (15) cyc(0, 1, 1);
      chk("slow15_pos", int'(paddle_pos), 250);
      cyc(0, 1, 1);
      chk("fast16_pos", int'(paddle_pos), 256);
      chk("fast16_dir", int'(paddle_dir), 1);

      // Both held: no motion; releasing up resumes slow down
      repeat (2 + D) cyc(1, 1, 0);
      repeat (5) cyc(1, 1, 1);
      chk("both_pos", int'(paddle_pos), 256);
      chk("both_mov", int'(paddle_mov), 0);
      repeat (2 + D) cyc(0, 1, 0);
      cyc(0, 1, 1);
      chk("release_pos", int'(paddle_pos), 258);

      // Walls
      repeat (90) cyc(0, 1, 1);
      chk("bottom_pos", int'(paddle_pos), 440);
      chk("bottom_mov", int'(paddle_mov), 1);
      repeat (2 + D) cyc(1, 0, 0);
      repeat (120) cyc(1, 0, 1);
      chk("top_pos", int'(paddle_pos), 0);
      chk("top_mov", int'(paddle_mov), 1);
      chk("top_dir", int'(paddle_dir), 0);

      // Reset while moving
      do_reset();

      // Random traffic
      for (int s = 0; s < 300; s++) begin
         seg = $urandom_range(0, 3);
         up = seg[0]; dn = seg[1];
         len = ($urandom_range(0, 4) == 0) ? $urandom_range(50, 200) : $urandom_range(1, 12);
         for (int c = 0; c < len; c++) cyc(up, dn, $urandom_range(0, 2) != 0);
         if ($urandom_range(0, 49) == 0) do_reset();
      end

`ifdef PADDLE_AUTO_TRACK_EN
      do_reset();
      chk_en = 1'b0;
      auto_en = 1'b1;
      ball_y_pos = 10'd400;
      repeat (100) cyc(0, 0, 1);
      chk("auto_pos", int'(paddle_pos), 378);
      chk("auto_mov", int'(paddle_mov), 0);
      auto_en = 1'b0;
      do_reset();
      chk_en = 1'b1;
`endif

      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
